// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised sequence detector.
// Holds the reset level and a ceiling-log2 helper used to size the fill counter.
package seq_det_pkg;

    localparam logic RESET_ACTIVE = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_detector_param.sv
// Mealy detector for a runtime-loadable PATTERN_LEN-bit pattern on a qualified serial stream,
// with a registered match pulse and a saturating match counter.
//
// fill        | meaning
// 0..LEN-2    | priming: fewer than LEN-1 valid bits held since last restart
// LEN-1       | armed: a valid bit matching pat completes a match
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN  = 3,
    parameter logic [PATTERN_LEN-1:0] PATTERN_INIT = 3'b101,
    parameter int                     CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   x_valid,
    input  logic                   x,
    input  logic                   overlap,
    input  logic                   pat_load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    input  logic                   cnt_clr,
    output logic                   y,
    output logic                   y_q,
    output logic [CNT_W-1:0]       match_count
);

    localparam int               FILL_W   = clog2(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PATTERN_LEN-2:0] hist, hist_nxt;
    logic [FILL_W-1:0]      fill, fill_nxt;
    logic [PATTERN_LEN-1:0] pat, pat_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [PATTERN_LEN-1:0] cand;
    logic                   armed;

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            hist        <= '0;
            fill        <= '0;
            pat         <= PATTERN_INIT;
            y_q         <= 1'b0;
            match_count <= '0;
        end else begin
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            pat         <= pat_nxt;
            y_q         <= y;
            match_count <= count_nxt;
        end
    end

    always_comb begin
        hist_nxt  = hist;
        fill_nxt  = fill;
        pat_nxt   = pat;
        count_nxt = match_count;
        if (pat_load) begin
            pat_nxt  = pat_in;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (x_valid) begin
            hist_nxt = cand[PATTERN_LEN-2:0];
            // Non-overlapping mode discards the bits consumed by the match
            if (y && !overlap) begin
                fill_nxt = '0;
            end else if (!armed) begin
                fill_nxt = fill + FILL_W'(1);
            end
        end
        if (cnt_clr) begin
            count_nxt = '0;
        end else if (y && (match_count != CNT_MAX)) begin
            count_nxt = match_count + CNT_W'(1);
        end
    end

    always_comb begin
        cand  = {hist, x};
        armed = (fill == FILL_MAX);
        y     = x_valid && !pat_load && (reset != RESET_ACTIVE) && armed && (cand == pat);
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table plus random traffic against a queue model.
// Two instances share stimulus; the second uses a 2-bit counter to exercise saturation.
module tb_seq_detector_param;

    localparam int L = 3;
    localparam logic [L-1:0] INIT = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, x_valid, x, overlap, pat_load, cnt_clr;
    logic [L-1:0] pat_in;
    logic         y, y_q, y_s, y_q_s;
    logic [7:0]   match_count;
    logic [1:0]   match_count_s;

    seq_detector_param #(.PATTERN_LEN(L), .PATTERN_INIT(INIT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y), .y_q(y_q), .match_count(match_count));

    seq_detector_param #(.PATTERN_LEN(L), .PATTERN_INIT(INIT), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y_s), .y_q(y_q_s), .match_count(match_count_s));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of valid bits since the last restart
    bit           m_bits[$];
    logic [L-1:0] m_pat;
    int           m_c8, m_c2;
    bit           m_yq, m_ey;

    function automatic bit model_y(bit rst, bit vld, bit xb, bit ld);
        logic [L-1:0] w;
        if (rst || ld || !vld || m_bits.size() < L - 1) return 1'b0;
        for (int i = 0; i < L - 1; i++) w[L-1-i] = m_bits[m_bits.size() - (L - 1) + i];
        w[0] = xb;
        return w == m_pat;
    endfunction

    task automatic model_edge(bit rst, bit vld, bit xb, bit ovl, bit ld, logic [L-1:0] pin, bit clr, bit ey);
        if (rst) begin
            m_bits.delete();
            m_pat = INIT;
            m_c8  = 0;
            m_c2  = 0;
            m_yq  = 1'b0;
            return;
        end
        if (ld) begin
            m_pat = pin;
            m_bits.delete();
        end else if (vld) begin
            if (ey && !ovl) m_bits.delete();
            else begin
                m_bits.push_back(xb);
                if (m_bits.size() > L - 1) void'(m_bits.pop_front());
            end
        end
        if (clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end else if (ey) begin
            m_c8 = (m_c8 == 255) ? 255 : m_c8 + 1;
            m_c2 = (m_c2 == 3) ? 3 : m_c2 + 1;
        end
        m_yq = ey;
    endtask

    logic s_y, s_ys;

    task automatic cycle(bit rst, bit vld, bit xb, bit ovl, bit ld, logic [L-1:0] pin, bit clr);
        @(negedge clk);
        reset = rst; x_valid = vld; x = xb; overlap = ovl;
        pat_load = ld; pat_in = pin; cnt_clr = clr;
        #1;
        s_y  = y;
        s_ys = y_s;
        m_ey = model_y(rst, vld, xb, ld);
        @(posedge clk);
        model_edge(rst, vld, xb, ovl, ld, pin, clr, m_ey);
        #1;
    endtask

    typedef struct {
        bit           rst, vld, xb, ovl, ld;
        logic [L-1:0] pin;
        bit           clr;
        bit           ey;
        int           ec, ecs;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit vld, bit xb, bit ovl, bit ld, logic [L-1:0] pin,
                                bit clr, bit ey, int ec, int ecs);
        vec_t v;
        v.rst = rst; v.vld = vld; v.xb = xb; v.ovl = ovl; v.ld = ld;
        v.pin = pin; v.clr = clr; v.ey = ey; v.ec = ec; v.ecs = ecs;
        tbl.push_back(v);
    endfunction

    function automatic void bit_v(bit xb, bit ovl, bit ey, int ec, int ecs);
        add(0, 1, xb, ovl, 0, 3'b000, 0, ey, ec, ecs);
    endfunction

    function automatic void rst_v();
        add(1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    endfunction

    initial begin
        reset = 1; x_valid = 0; x = 0; overlap = 1; pat_load = 0; pat_in = '0; cnt_clr = 0;
        m_pat = INIT; m_c8 = 0; m_c2 = 0; m_yq = 0;

        // 1: overlapping 1,0,1,0,1
        rst_v();
        bit_v(1, 1, 0, 0, 0); bit_v(0, 1, 0, 0, 0); bit_v(1, 1, 1, 1, 1);
        bit_v(0, 1, 0, 1, 1); bit_v(1, 1, 1, 2, 2);
        // 2: non-overlapping 1,0,1,0,1,0,1
        rst_v();
        bit_v(1, 0, 0, 0, 0); bit_v(0, 0, 0, 0, 0); bit_v(1, 0, 1, 1, 1);
        bit_v(0, 0, 0, 1, 1); bit_v(1, 0, 0, 1, 1); bit_v(0, 0, 0, 1, 1); bit_v(1, 0, 1, 2, 2);
        // 3: gaps with x=1 on invalid cycles
        rst_v();
        bit_v(1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0); add(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0);
        bit_v(0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0);
        bit_v(1, 1, 1, 1, 1);
        // 4: reset mid-pattern, asserted alongside a would-be completing bit
        rst_v();
        bit_v(1, 1, 0, 0, 0); bit_v(0, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
        bit_v(1, 1, 0, 0, 0); bit_v(0, 1, 0, 0, 0); bit_v(1, 1, 1, 1, 1);
        // 5: pattern load drops the same-cycle bit
        rst_v();
        add(0, 1, 1, 1, 1, 3'b110, 0, 0, 0, 0);
        bit_v(1, 1, 0, 0, 0); bit_v(1, 1, 0, 0, 0); bit_v(0, 1, 1, 1, 1);
        bit_v(1, 1, 0, 1, 1); bit_v(0, 1, 0, 1, 1); bit_v(1, 1, 0, 1, 1);
        // 6: pattern 111, saturation of the 2-bit counter, clear beats increment
        rst_v();
        add(0, 0, 0, 1, 1, 3'b111, 0, 0, 0, 0);
        bit_v(1, 1, 0, 0, 0); bit_v(1, 1, 0, 0, 0); bit_v(1, 1, 1, 1, 1);
        bit_v(1, 1, 1, 2, 2); bit_v(1, 1, 1, 3, 3); bit_v(1, 1, 1, 4, 3);
        add(0, 1, 1, 1, 0, 3'b000, 1, 1, 0, 0);
        bit_v(1, 1, 1, 1, 1);
        // reset restores PATTERN_INIT
        rst_v();
        bit_v(1, 1, 0, 0, 0); bit_v(1, 1, 0, 0, 0); bit_v(1, 1, 0, 0, 0);
        bit_v(0, 1, 0, 0, 0); bit_v(1, 1, 1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].xb, tbl[i].ovl, tbl[i].ld, tbl[i].pin, tbl[i].clr);
            chk($sformatf("vec%0d_y", i), s_y, tbl[i].ey);
            chk($sformatf("vec%0d_y_s", i), s_ys, tbl[i].ey);
            chk($sformatf("vec%0d_y_q", i), y_q, tbl[i].ey);
            chk($sformatf("vec%0d_y_q_s", i), y_q_s, tbl[i].ey);
            chk($sformatf("vec%0d_cnt", i), match_count, tbl[i].ec);
            chk($sformatf("vec%0d_cnt_s", i), match_count_s, tbl[i].ecs);
        end

        for (int n = 0; n < 3000; n++) begin
            bit           rr, vv, xx, oo, ll, cc;
            logic [L-1:0] pp;
            rr = ($urandom_range(0, 99) == 0);
            vv = ($urandom_range(0, 3) != 0);
            xx = 1'($urandom_range(0, 1));
            oo = 1'($urandom_range(0, 1));
            ll = ($urandom_range(0, 31) == 0);
            cc = ($urandom_range(0, 299) == 0);
            pp = L'($urandom);
            cycle(rr, vv, xx, oo, ll, pp, cc);
            chk($sformatf("rnd%0d_y", n), s_y, m_ey);
            chk($sformatf("rnd%0d_y_s", n), s_ys, m_ey);
            chk($sformatf("rnd%0d_y_q", n), y_q, m_yq);
            chk($sformatf("rnd%0d_cnt", n), match_count, m_c8);
            chk($sformatf("rnd%0d_cnt_s", n), match_count_s, m_c2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Mealy sequence detector, the successor to the fixed 3-bit "101" detector. It matches a runtime-loadable PATTERN_LEN-bit pattern on a qualified serial bit stream, in either overlapping or non-overlapping mode. It provides a combinational Mealy match pulse, a registered copy of that pulse, and a saturating match counter. It sits on a serial input path as a framing and marker detector.

Parameters:
PATTERN_LEN, 3, number of bits in the pattern (must be >= 2).
PATTERN_INIT, 3'b101, pattern value loaded at reset; MSB is the oldest bit.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
x_valid  input  1  qualifies x; bits with x_valid=0 are ignored.
x  input  1  serial data bit.
overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
pat_load  input  1  loads pat_in into the pattern register and restarts detection.
pat_in  input  PATTERN_LEN  new pattern value, MSB = oldest bit.
cnt_clr  input  1  clears match_count.
y  output  1  Mealy match: high in the same cycle as the completing bit.
y_q  output  1  y registered, one cycle later.
match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: hist=0, fill=0, pat=PATTERN_INIT, y_q=0, match_count=0. y is forced to 0 while reset=1. Reset overrides every other input.
- State:
  - hist: PATTERN_LEN-1 bits, newest bit in the LSB.
  - fill: 0..PATTERN_LEN-1, counts valid bits held since the last restart; saturates at PATTERN_LEN-1.
  - pat: PATTERN_LEN-bit pattern register.
- Candidate: cand = {hist, x}.
- Match condition: y = x_valid & ~pat_load & ~reset & (fill == PATTERN_LEN-1) & (cand == pat). This is purely combinational from the current state and inputs (Mealy), so latency is 0 cycles.
- On a valid bit (x_valid=1, pat_load=0):
  - hist <= cand[PATTERN_LEN-2:0].
  - If y=1 and overlap=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, PATTERN_LEN-1).
- x_valid=0: hist and fill hold; y=0. Gaps do not break a partial match.
- pat_load=1:
  - pat <= pat_in, hist <= 0, fill <= 0.
  - Any x in the same cycle is dropped and y=0 (pat_load wins).
  - Detection restarts from an empty history.
- overlap may change at any time; it is sampled only in cycles where y=1.
- y_q <= y every cycle.
- match_count:
  - cnt_clr=1: count <= 0. This has priority over an increment in the same cycle; the match is still reported on y and y_q.
  - Otherwise, when y=1, count increments and saturates at 2^CNT_W-1 (no wrap).
- Mid-operation reset: partial history is discarded. Bits received before reset never contribute to a later match.
- The all-zero pattern is legal; the fill gating prevents a false match on the reset history.

Decomposition:
- Shared package seq_det_pkg: reset level constant RESET_ACTIVE=1'b1, and a function clog2 used to size fill.
- No sub-module needed: one flat module with a register block and a combinational match/next-state block.
- An optional sub-module sat_counter (CNT_W, inc, clr) is reusable for match_count.

Test Plan:
1. Defaults, overlap=1, x=1,0,1,0,1 on consecutive valid cycles -> y=1 on bits 3 and 5; y_q=1 on the following cycles; match_count=2.
2. overlap=0, same stream 1,0,1,0,1 -> y=1 on bit 3 only; match_count=1; the next bits 0,1 then give y=1 at the 7th bit.
3. Stream 1,(x_valid=0 x2),0,(x_valid=0),1 -> y=1 on the final valid 1; y=0 on every invalid cycle, even with x=1.
4. reset pulse after bits 1,0, then bit 1 -> y=0. Afterwards 0,1 -> y=1 on the second bit after reset's 1; match_count=1.
5. pat_load with pat_in=3'b110 and x_valid=1, x=1 in the same cycle -> y=0, bit dropped. Then 1,1,0 -> y=1 on the 0. A following 1,0,1 -> y=0.
6. CNT_W=2, overlap=1, stream 1,1,1,1,1,1 with pattern 3'b111 -> y=1 on bits 3..6; match_count=3 (saturated). cnt_clr together with a match -> count=0, y=1.
